// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising Fibonacci-LFSR bit-sequence checker.
// Define PRBS_CHK_BITCNT_EN to add the saturating locked-bit counter bit_cnt.
module lfsr_checker #(
  parameter int               WIDTH       = 7,
  parameter logic [WIDTH-1:0] TAPS        = 7'h60,
  parameter int               LOCK_CNT    = 16,
  parameter int               LOSS_THRESH = 4,
  parameter int               ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_THRESH);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] w_s_nxt;
  logic [FW-1:0]    r_fill_cnt;
  logic [FW-1:0]    w_fill_nxt;
  logic [FW-1:0]    w_fill_inc;
  logic [7:0]       r_match_cnt;
  logic [7:0]       w_match_nxt;
  logic [7:0]       w_match_inc;
  logic [3:0]       r_bad_cnt;
  logic [3:0]       w_bad_nxt;
  logic [3:0]       w_bad_inc;

  logic             r_locked;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_cnt;

  logic w_pred;
  logic w_miss;
  logic w_err_evt;
  logic w_locked_nxt;

  assign w_pred      = ^(r_s & TAPS);
  assign w_miss      = din ^ w_pred;
  assign w_fill_inc  = r_fill_cnt + FW'(1);
  assign w_match_inc = r_match_cnt + 8'd1;
  assign w_bad_inc   = r_bad_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_fill_nxt  = r_fill_cnt;
    w_match_nxt = r_match_cnt;
    w_bad_nxt   = r_bad_cnt;
    if (din_vld) begin
      unique case (r_state)
        HUNT: begin
          w_s_nxt    = {r_s[WIDTH-2:0], din};
          w_fill_nxt = w_fill_inc;
          if (r_fill_cnt == FILL_LAST) begin
            w_fill_nxt = '0;
            if (|w_s_nxt) begin
              w_state_nxt = VERIFY;
              w_match_nxt = '0;
            end
          end
        end
        VERIFY: begin
          w_s_nxt = {r_s[WIDTH-2:0], din};
          if (w_miss) begin
            w_state_nxt = HUNT;
            w_fill_nxt  = '0;
          end else begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == LOCK_LAST) begin
              w_state_nxt = LOCK;
              w_bad_nxt   = '0;
            end
          end
        end
        LOCK: begin
          // Free-run on our own prediction so line errors never pollute it.
          w_s_nxt = {r_s[WIDTH-2:0], w_pred};
          if (w_miss) begin
            w_bad_nxt = w_bad_inc;
            if (w_bad_inc == LOSS_LAST) begin
              w_state_nxt = HUNT;
              w_fill_nxt  = '0;
            end
          end else if (r_bad_cnt != 4'd0) begin
            w_bad_nxt = r_bad_cnt - 4'd1;
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_fill_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_err_evt    = 1'b0;
    w_locked_nxt = (w_state_nxt == LOCK);
    if (din_vld && (r_state == LOCK)) begin
      w_err_evt = w_miss;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s         <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_bad_cnt   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_s         <= w_s_nxt;
      r_fill_cnt  <= w_fill_nxt;
      r_match_cnt <= w_match_nxt;
      r_bad_cnt   <= w_bad_nxt;
      r_locked    <= w_locked_nxt;
      r_err_pulse <= w_err_evt;
      if (clr_cnt) begin
        r_err_cnt <= '0;
      end else if (w_err_evt && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] r_bit_cnt;
  logic        w_bit_evt;

  // Erroneous bits count too, so err_cnt/bit_cnt gives the raw BER.
  assign w_bit_evt = din_vld && (r_state == LOCK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
    end else if (clr_cnt) begin
      r_bit_cnt <= '0;
    end else if (w_bit_evt && !(&r_bit_cnt)) begin
      r_bit_cnt <= r_bit_cnt + 32'd1;
    end
  end

  assign bit_cnt = r_bit_cnt;
`else
  // No bit counter in this build; err_cnt alone reports link quality.
`endif

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial pseudo-random bit-sequence checker, the receive end of our LFSR pattern generators. It self-synchronises to an incoming Fibonacci-LFSR bit stream, declares lock after a run of correct predictions, then flags and counts bit errors against its own free-running prediction. It sits at the far end of a link or loopback path under test, fed one bit per qualified clock.

## Interface
- WIDTH, 7: LFSR length, 3..32.
- TAPS, 7'h60: feedback mask. Prediction is the XOR of all state bits selected by TAPS. The default is PRBS7, x^7+x^6+1.
- LOCK_CNT, 16: consecutive correct predictions required to lock, 1..255.
- LOSS_THRESH, 4: leaky-bucket level that drops lock, 1..15.
- ERR_W, 16: error counter width.
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- din, input, 1: received serial bit.
- din_vld, input, 1: din is valid this cycle. When low, the block holds all state.
- clr_cnt, input, 1: synchronous clear of the counters.
- locked, output, 1: sequence lock indicator.
- err_pulse, output, 1: one-cycle strobe for a mismatch detected while locked.
- err_cnt, output, ERR_W: saturating count of errors detected while locked.
- bit_cnt, output, 32: present only with PRBS_CHK_BITCNT_EN.

## Operation
- State register s[WIDTH-1:0]. s[0] holds the newest bit.
- pred = ^(s & TAPS).
- Shifting means s <= {s[WIDTH-2:0], x}.
- A bit is processed only on cycles with din_vld=1.

FSM states and transitions:
- **HUNT** (reset state)
  - Shift din into s and increment fill_cnt.
  - When the WIDTH-th bit arrives:
    - If the resulting s is nonzero, go to VERIFY with match_cnt=0.
    - If the resulting s is all zero, clear fill_cnt and stay in HUNT.
- **VERIFY**
  - Compare din against pred, then shift din (the received bit) into s.
  - On a match, increment match_cnt. On reaching LOCK_CNT, go to LOCKED with bad_cnt=0.
  - On a mismatch, go to HUNT with fill_cnt=0.
- **LOCKED**
  - Shift pred (not din) into s, so line errors do not corrupt the prediction.
  - On a mismatch: pulse err_pulse, increment err_cnt (saturating at all-ones), and increment bad_cnt.
  - On a match: decrement bad_cnt, floored at 0.
  - When bad_cnt reaches LOSS_THRESH, go to HUNT with fill_cnt=0. That final mismatch is still counted.

Outputs and counters:
- locked = (state == LOCKED), registered.
- clr_cnt zeroes err_cnt and bit_cnt. It has priority over an increment in the same cycle, and does not affect the FSM.
- Reset values:
  - state=HUNT
  - s=0
  - fill_cnt=0, match_cnt=0, bad_cnt=0
  - locked=0, err_pulse=0, err_cnt=0, bit_cnt=0
- Reset mid-operation returns immediately to these values. No partial lock is retained.

## Timing
- Single clock domain. All outputs are registered.
- err_pulse is high for exactly the cycle after the edge that sampled the erroneous bit. Back-to-back erroneous bits give a continuous high.
- locked rises at the edge that samples the LOCK_CNT-th consecutive match. With continuous din_vld from an error-free stream, locked is high after WIDTH+LOCK_CNT valid bits.
- locked falls at the edge that samples the mismatch taking bad_cnt to LOSS_THRESH. err_pulse for that same bit is still asserted.
- din_vld=0 cycles are fully transparent: no shift and no counter change.

## Configuration
- PRBS_CHK_BITCNT_EN defined:
  - Adds bit_cnt, a 32-bit saturating count of valid bits processed while in LOCKED, including erroneous ones.
  - Cleared by clr_cnt and by rst.
  - Lets software derive the bit-error rate from err_cnt/bit_cnt.
- Not defined: the bit_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- **Clean lock:** PRBS7 generator seeded 7'h7F, din_vld=1 continuously. Required:
  - locked=0 through valid bit 22.
  - locked=1 after the 23rd edge.
  - err_cnt stays 0 over 1000 bits.
- **Single error:** while locked, invert one bit. Required:
  - err_pulse is one cycle wide, err_cnt=1, locked stays 1.
  - Subsequent correct bits give no further errors, proving the predictor was not polluted.
- **Loss of lock:** while locked, feed 4 consecutive inverted bits. Required:
  - err_cnt=4 and locked drops on the 4th.
  - Relock completes 23 bits after a clean stream resumes.
- **All-zero input:** feed 50 zero bits. Required: locked stays 0, FSM stays in HUNT, err_cnt=0.
- **Gaps and clear:**
  - Randomly deassert din_vld (about 50%) on a clean stream: lock timing counted in valid bits is unchanged.
  - Assert clr_cnt in the same cycle as an error: err_cnt reads 0 afterwards.
- **Reset mid-VERIFY and saturation:**
  - Assert rst after 10 matches in VERIFY: all outputs return to reset values.
  - With ERR_W=4, inject 20 errors while keeping lock (alternating with 2 good bits each): err_cnt holds at 15.
  - With PRBS_CHK_BITCNT_EN, bit_cnt equals the number of valid bits processed while locked.
